bird_frame_sequencer: RTL and testbench
=======================================

Name: bird_frame_sequencer

Overview:
Per-frame controller for the bird sprite drawer. On each frame tick it runs the drawer twice: first to erase the bird at its old position, then to draw it at the new one. When the bird is finished, it grants the shared framebuffer write port to one auxiliary drawer (pipes/score) through a req/grant handshake. It sits between the game-logic position update and the VGA framebuffer write port, and owns all framebuffer writes.

Parameters:
SPRITE_W, 34, sprite width in pixels (informational; drawer owns geometry)
SPRITE_H, 24, sprite height in pixels (informational)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse, start of frame update
new_bird_x  input  11  bird x for this frame, sampled on accepted frame_tick
new_bird_y  input  11  bird y for this frame, sampled on accepted frame_tick
bird_start  output  1  start to drawer; held until bird_done
bird_x  output  11  sprite origin x driven to drawer
bird_y  output  11  sprite origin y driven to drawer
bird_done  input  1  drawer done (high while start held after completion)
bird_px_x  input  11  drawer pixel x
bird_px_y  input  11  drawer pixel y
bird_px_color  input  1  drawer template bit (1 = sprite pixel)
aux_req  input  1  aux drawer requests port; held until aux_done
aux_grant  output  1  aux owns write port
aux_done  input  1  aux finished
aux_px_x  input  11  aux pixel x
aux_px_y  input  11  aux pixel y
aux_px_color  input  1  aux pixel color
aux_px_we  input  1  aux write enable
fb_x  output  11  framebuffer write x
fb_y  output  11  framebuffer write y
fb_color  output  1  framebuffer write data
fb_we  output  1  framebuffer write enable
busy  output  1  high in any state except S_IDLE
frame_done  output  1  one-cycle pulse on return to S_IDLE
overrun  output  1  one-cycle pulse when a frame_tick is dropped

Behaviour:
- Reset: state S_IDLE, have_old=0, cur/old positions=0. All outputs 0 on the cycle after reset is sampled.
- States: S_IDLE, S_ERASE, S_ERASE_REL, S_DRAW, S_DRAW_REL, S_AUX, S_AUX_REL.
- S_IDLE, on frame_tick: cur_pos <= new_bird. Next state is S_ERASE if have_old, else S_DRAW.
- S_ERASE: bird_start=1, bird_x/y=old_pos. On bird_done go to S_ERASE_REL.
- S_ERASE_REL: bird_start=0 for exactly one cycle (drawer returns to idle), then go to S_DRAW.
- S_DRAW: bird_start=1, bird_x/y=cur_pos. On bird_done go to S_DRAW_REL.
- S_DRAW_REL: bird_start=0; old_pos <= cur_pos; have_old <= 1. Next state is S_AUX if aux_req, else S_IDLE.
- S_AUX: aux_grant=1. On aux_done go to S_AUX_REL.
- S_AUX_REL: aux_grant=0, then S_IDLE. aux_req is only checked at S_DRAW_REL; a request raised later waits for the next frame.
- frame_done pulses on the transition cycle into S_IDLE from S_DRAW_REL or S_AUX_REL.
- bird_x/y outputs are 0 outside S_ERASE/S_DRAW.
- Write port mux (combinational, zero latency):
  - ERASE/DRAW: fb_x/y = bird_px_x/y; fb_we = bird_px_color & ~bird_done & ~first. first is high only on the state-entry cycle, which suppresses the duplicate write of pixel (0,0) while the drawer is still idle. Result: exactly one write per set template bit. Zero template bits are transparent (no write).
  - fb_color = 0 in ERASE, 1 in DRAW.
  - S_AUX: fb_* = aux_px_*, with fb_we = aux_px_we & ~aux_done.
  - All other states: fb_we=0, fb_x/y/color=0.
- frame_tick while busy: tick is ignored, overrun pulses the same cycle, and cur_pos is not updated.
- Reset mid-operation: return to S_IDLE and clear have_old. The next frame then skips erase, so no stale erase is attempted.
- Coordinates pass through unmodified at 11 bits; no clipping.

Test Plan:
- Reset; frame_tick with new=(100,100), have_old=0 -> S_ERASE skipped; bird_start high with bird_x/y=(100,100); fb_we count equals number of 1s in template, all fb_color=1; single frame_done pulse; no aux_grant.
- Second frame_tick with new=(100,140) -> erase at (100,100), fb_color=0, write count equals ones count; one cycle bird_start=0; then draw at (100,140) with fb_color=1.
- aux_req held high during bird draw -> aux_grant rises the cycle after S_DRAW_REL; fb_* track aux_px_*; aux_done -> grant drops next cycle, frame_done pulses.
- frame_tick pulsed mid-draw with new=(5,5) -> overrun pulse, current frame unaffected, next frame uses a later tick's position.
- reset asserted during S_DRAW -> outputs 0 next cycle; next frame_tick goes directly to S_DRAW (no erase).
- Template pixel (0,0)=1 -> exactly one fb_we at bird origin per phase.

Source files
------------

// File: rtl/bird_frame_sequencer.sv
// bird_frame_sequencer: per-frame erase/draw sequencing of the bird sprite plus aux drawer port grant
module bird_frame_sequencer #(
  parameter int SPRITE_W = 34,
  parameter int SPRITE_H = 24
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  input  logic [10:0] new_bird_x_i,
  input  logic [10:0] new_bird_y_i,
  output logic        bird_start_o,
  output logic [10:0] bird_x_o,
  output logic [10:0] bird_y_o,
  input  logic        bird_done_i,
  input  logic [10:0] bird_px_x_i,
  input  logic [10:0] bird_px_y_i,
  input  logic        bird_px_color_i,
  input  logic        aux_req_i,
  output logic        aux_grant_o,
  input  logic        aux_done_i,
  input  logic [10:0] aux_px_x_i,
  input  logic [10:0] aux_px_y_i,
  input  logic        aux_px_color_i,
  input  logic        aux_px_we_i,
  output logic [10:0] fb_x_o,
  output logic [10:0] fb_y_o,
  output logic        fb_color_o,
  output logic        fb_we_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        overrun_o
);
  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_ERASE_REL, S_DRAW, S_DRAW_REL, S_AUX, S_AUX_REL} state_t;
  state_t state_q, state_d;
  logic first_q, have_old_q, have_old_d;
  logic [10:0] cur_x_q, cur_y_q, old_x_q, old_y_q, cur_x_d, cur_y_d, old_x_d, old_y_d;
  if (SPRITE_W < 1 || SPRITE_H < 1) begin : g_bad_size
    $error("sprite dimensions must be positive");
  end
  // state and position registers; first_q marks the entry cycle of every state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      have_old_q <= 1'b0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      old_x_q    <= '0;
      old_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= state_d != state_q;
      have_old_q <= have_old_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      old_x_q    <= old_x_d;
      old_y_q    <= old_y_d;
    end
  end
  // next-state logic and the framebuffer write-port mux
  always_comb begin
    state_d      = state_q;
    have_old_d   = have_old_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    bird_start_o = 1'b0;
    bird_x_o     = '0;
    bird_y_o     = '0;
    aux_grant_o  = 1'b0;
    fb_x_o       = '0;
    fb_y_o       = '0;
    fb_color_o   = 1'b0;
    fb_we_o      = 1'b0;
    frame_done_o = 1'b0;
    busy_o       = state_q != S_IDLE;
    overrun_o    = frame_tick_i && state_q != S_IDLE;
    case (state_q)
      S_IDLE: if (frame_tick_i) begin
        cur_x_d = new_bird_x_i;
        cur_y_d = new_bird_y_i;
        state_d = have_old_q ? S_ERASE : S_DRAW;
      end
      S_ERASE, S_DRAW: begin
        bird_start_o = 1'b1;
        bird_x_o     = state_q == S_DRAW ? cur_x_q : old_x_q;
        bird_y_o     = state_q == S_DRAW ? cur_y_q : old_y_q;
        fb_x_o       = bird_px_x_i;
        fb_y_o       = bird_px_y_i;
        fb_color_o   = state_q == S_DRAW;
        fb_we_o      = bird_px_color_i & ~bird_done_i & ~first_q;
        if (bird_done_i) state_d = state_q == S_DRAW ? S_DRAW_REL : S_ERASE_REL;
      end
      S_ERASE_REL: state_d = S_DRAW;
      S_DRAW_REL: begin
        old_x_d      = cur_x_q;
        old_y_d      = cur_y_q;
        have_old_d   = 1'b1;
        frame_done_o = !aux_req_i;
        state_d      = aux_req_i ? S_AUX : S_IDLE;
      end
      S_AUX: begin
        aux_grant_o = 1'b1;
        fb_x_o      = aux_px_x_i;
        fb_y_o      = aux_px_y_i;
        fb_color_o  = aux_px_color_i;
        fb_we_o     = aux_px_we_i & ~aux_done_i;
        if (aux_done_i) state_d = S_AUX_REL;
      end
      S_AUX_REL: begin
        frame_done_o = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_bird_frame_sequencer.sv
// tb_bird_frame_sequencer: scoreboard bench with a behavioural 4x3 sprite drawer
module tb_bird_frame_sequencer;
  logic clk = 0, reset = 1, frame_tick = 0;
  logic [10:0] new_bird_x = 0, new_bird_y = 0;
  logic bird_start, bird_done;
  logic [10:0] bird_x, bird_y, bird_px_x, bird_px_y;
  logic bird_px_color;
  logic aux_req = 0, aux_grant, aux_done = 0, aux_px_color = 0, aux_px_we = 0;
  logic [10:0] aux_px_x = 0, aux_px_y = 0;
  logic [10:0] fb_x, fb_y;
  logic fb_color, fb_we, busy, frame_done, overrun;
  int checks = 0, passes = 0;
  int wr_cnt = 0, fd_cnt = 0, ov_cnt = 0, gr_cnt = 0;
  bit sb_on = 1;
  logic [22:0] q[$];
  logic [11:0] tmpl = 12'b1010_0110_1101;
  logic run, done;
  int idx;

  bird_frame_sequencer dut (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(frame_tick),
    .new_bird_x_i(new_bird_x), .new_bird_y_i(new_bird_y),
    .bird_start_o(bird_start), .bird_x_o(bird_x), .bird_y_o(bird_y),
    .bird_done_i(bird_done), .bird_px_x_i(bird_px_x), .bird_px_y_i(bird_px_y),
    .bird_px_color_i(bird_px_color), .aux_req_i(aux_req), .aux_grant_o(aux_grant),
    .aux_done_i(aux_done), .aux_px_x_i(aux_px_x), .aux_px_y_i(aux_px_y),
    .aux_px_color_i(aux_px_color), .aux_px_we_i(aux_px_we),
    .fb_x_o(fb_x), .fb_y_o(fb_y), .fb_color_o(fb_color), .fb_we_o(fb_we),
    .busy_o(busy), .frame_done_o(frame_done), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset || !bird_start) begin
      run <= 0; done <= 0; idx <= 0;
    end else if (!run && !done) run <= 1;
    else if (run) begin
      if (idx == 11) begin run <= 0; done <= 1; end
      else idx <= idx + 1;
    end
  end
  assign bird_done = done;
  assign bird_px_x = bird_x + 11'(idx % 4);
  assign bird_px_y = bird_y + 11'(idx / 4);
  assign bird_px_color = tmpl[idx];

  always @(negedge clk) begin
    logic [22:0] e;
    if (fb_we) wr_cnt++;
    if (frame_done) fd_cnt++;
    if (overrun) ov_cnt++;
    if (aux_grant) gr_cnt++;
    if (fb_we && sb_on) begin
      checks++;
      if (q.size() == 0) $display("FAIL sb_unexpected_write got x=%0d y=%0d c=%0d, want none", fb_x, fb_y, fb_color);
      else begin
        e = q.pop_front();
        if ({fb_x, fb_y, fb_color} !== e)
          $display("FAIL sb_write got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d", fb_x, fb_y, fb_color, e[22:12], e[11:1], e[0]);
        else passes++;
      end
    end
  end

  task automatic push_sprite(input logic [10:0] x, input logic [10:0] y, input logic c);
    for (int i = 0; i < 12; i++)
      if (tmpl[i]) q.push_back({x + 11'(i % 4), y + 11'(i / 4), c});
  endtask

  task automatic tick(input logic [10:0] x, input logic [10:0] y);
    @(posedge clk); #1 frame_tick = 1; new_bird_x = x; new_bird_y = y;
    @(posedge clk); #1 frame_tick = 0;
  endtask

  task automatic wait_idle(input string n);
    for (int k = 0; k < 500 && busy; k++) @(negedge clk);
    #1 checks++;
    if (busy) $display("FAIL %s_timeout busy=%0d, want 0", n, busy); else passes++;
  endtask

  task automatic check_q_empty(input string n);
    checks++;
    if (q.size() != 0) $display("FAIL %s_missing_writes got %0d pending, want 0", n, q.size()); else passes++;
    q.delete();
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checks += 5;
    if (busy !== 0) $display("FAIL rst_busy got %0d want 0", busy); else passes++;
    if (bird_start !== 0) $display("FAIL rst_start got %0d want 0", bird_start); else passes++;
    if (fb_we !== 0) $display("FAIL rst_we got %0d want 0", fb_we); else passes++;
    if (aux_grant !== 0) $display("FAIL rst_grant got %0d want 0", aux_grant); else passes++;
    if ({frame_done, overrun, bird_x, bird_y} !== 24'd0) $display("FAIL rst_outs got %h want 0", {frame_done, overrun, bird_x, bird_y}); else passes++;
  endtask

  task automatic test_first_frame;
    int w0, f0, g0;
    push_sprite(100, 100, 1);
    w0 = wr_cnt; f0 = fd_cnt; g0 = gr_cnt;
    tick(100, 100);
    @(negedge clk);
    checks += 2;
    if (bird_start !== 1) $display("FAIL f1_start got %0d want 1", bird_start); else passes++;
    if ({bird_x, bird_y} !== {11'd100, 11'd100}) $display("FAIL f1_pos got %0d,%0d want 100,100", bird_x, bird_y); else passes++;
    wait_idle("f1");
    checks += 3;
    if (wr_cnt - w0 != $countones(tmpl)) $display("FAIL f1_wr_count got %0d want %0d", wr_cnt - w0, $countones(tmpl)); else passes++;
    if (fd_cnt - f0 != 1) $display("FAIL f1_frame_done got %0d want 1", fd_cnt - f0); else passes++;
    if (gr_cnt != g0) $display("FAIL f1_grant got %0d want 0", gr_cnt - g0); else passes++;
    check_q_empty("f1");
  endtask

  task automatic test_erase_draw;
    int w0, rel;
    push_sprite(100, 100, 0);
    push_sprite(100, 140, 1);
    w0 = wr_cnt; rel = 0;
    tick(100, 140);
    @(negedge clk);
    checks++;
    if ({bird_start, bird_x, bird_y} !== {1'b1, 11'd100, 11'd100}) $display("FAIL f2_erase_pos got %0d,%0d,%0d want 1,100,100", bird_start, bird_x, bird_y); else passes++;
    for (int k = 0; k < 500 && busy; k++) begin
      if (!bird_start) rel++;
      @(negedge clk);
    end
    #1 checks += 3;
    if (busy) $display("FAIL f2_timeout busy=%0d want 0", busy); else passes++;
    if (rel != 2) $display("FAIL f2_release_cycles got %0d want 2", rel); else passes++;
    if (wr_cnt - w0 != 2 * $countones(tmpl)) $display("FAIL f2_wr_count got %0d want %0d", wr_cnt - w0, 2 * $countones(tmpl)); else passes++;
    check_q_empty("f2");
  endtask

  task automatic test_aux;
    logic ps;
    int f0;
    push_sprite(100, 140, 0);
    push_sprite(200, 50, 1);
    aux_req = 1;
    f0 = fd_cnt;
    tick(200, 50);
    ps = 1;
    for (int k = 0; k < 500 && !aux_grant; k++) begin
      ps = bird_start;
      @(negedge clk);
    end
    checks += 2;
    if (aux_grant !== 1) $display("FAIL aux_grant_rise got %0d want 1", aux_grant); else passes++;
    if (ps !== 0) $display("FAIL aux_grant_after_rel got start=%0d before grant, want 0", ps); else passes++;
    @(posedge clk); #1 aux_px_we = 1; aux_px_x = 10; aux_px_y = 11; aux_px_color = 1; q.push_back({11'd10, 11'd11, 1'b1});
    @(posedge clk); #1 aux_px_we = 0; aux_px_x = 99; aux_px_y = 98;
    @(posedge clk); #1 aux_px_we = 1; aux_px_x = 12; aux_px_y = 13; aux_px_color = 0; q.push_back({11'd12, 11'd13, 1'b0});
    @(posedge clk); #1 aux_px_x = 14; aux_px_y = 15; aux_px_color = 1; aux_done = 1;
    @(posedge clk); #1 aux_done = 0; aux_req = 0; aux_px_we = 0;
    @(negedge clk);
    checks += 2;
    if (aux_grant !== 0) $display("FAIL aux_grant_drop got %0d want 0", aux_grant); else passes++;
    if (frame_done !== 1) $display("FAIL aux_frame_done got %0d want 1", frame_done); else passes++;
    wait_idle("aux");
    checks++;
    if (fd_cnt - f0 != 1) $display("FAIL aux_done_count got %0d want 1", fd_cnt - f0); else passes++;
    check_q_empty("aux");
  endtask

  task automatic test_overrun;
    int o0;
    push_sprite(200, 50, 0);
    push_sprite(300, 20, 1);
    o0 = ov_cnt;
    tick(300, 20);
    for (int k = 0; k < 500 && bird_x != 300; k++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1 frame_tick = 1; new_bird_x = 5; new_bird_y = 5;
    @(negedge clk);
    checks++;
    if (overrun !== 1) $display("FAIL ovr_pulse got %0d want 1", overrun); else passes++;
    @(posedge clk); #1 frame_tick = 0;
    wait_idle("ovr");
    checks++;
    if (ov_cnt - o0 != 1) $display("FAIL ovr_count got %0d want 1", ov_cnt - o0); else passes++;
    check_q_empty("ovr");
    push_sprite(300, 20, 0);
    push_sprite(40, 60, 1);
    tick(40, 60);
    @(negedge clk);
    checks++;
    if ({bird_x, bird_y} !== {11'd300, 11'd20}) $display("FAIL ovr_old_pos got %0d,%0d want 300,20", bird_x, bird_y); else passes++;
    wait_idle("ovr2");
    check_q_empty("ovr2");
  endtask

  task automatic test_reset_mid;
    sb_on = 0;
    tick(60, 60);
    for (int k = 0; k < 500 && bird_x != 60; k++) @(negedge clk);
    repeat (4) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks += 2;
    if ({busy, bird_start, fb_we, aux_grant} !== 4'd0) $display("FAIL rmid_outs got %b want 0000", {busy, bird_start, fb_we, aux_grant}); else passes++;
    if ({bird_x, bird_y, fb_x, fb_y} !== 44'd0) $display("FAIL rmid_coords got %h want 0", {bird_x, bird_y, fb_x, fb_y}); else passes++;
    q.delete();
    sb_on = 1;
    push_sprite(7, 9, 1);
    tick(7, 9);
    @(negedge clk);
    checks++;
    if ({bird_start, bird_x, bird_y} !== {1'b1, 11'd7, 11'd9}) $display("FAIL rmid_no_erase got %0d,%0d,%0d want 1,7,9", bird_start, bird_x, bird_y); else passes++;
    wait_idle("rmid");
    check_q_empty("rmid");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_erase_draw();
    test_aux();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
